// File: rtl/sprdma.sv
// Sprite DMA sequencer: eight sprites, two fixed fetch slots each per line,
// with register snooping of position/control words and CPU pointer writes.
module sprdma #(
  parameter logic [8:0] VBEND    = 9'd25,
  parameter logic [8:0] SLOTBASE = 9'd42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spren,
  input  logic [8:0]  horbeam,
  input  logic [8:0]  verbeam,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  output logic        dma,
  output logic [19:0] address_out,
  output logic [7:0]  reg_address_out
);

  typedef enum logic [1:0] {IDLE, FETCHCTL, WAIT, DATA} state_t;
  typedef enum logic [1:0] {K_POS, K_CTL, K_DATA, K_DATB} kind_t;

  state_t      state_q  [8];
  state_t      state_d  [8];
  logic [19:0] ptr_q    [8];
  logic [19:0] ptr_d    [8];
  logic [8:0]  vstart_q [8];
  logic [8:0]  vstart_d [8];
  logic [8:0]  vstop_q  [8];
  logic [8:0]  vstop_d  [8];

  logic [8:0] hoff;
  logic       slot_hit;
  logic       slot_b;
  logic [2:0] sn;
  logic       fetch;
  kind_t      kind;
  state_t     nxt;

  assign hoff     = horbeam - SLOTBASE;
  assign slot_hit = (hoff < 9'd64) && (hoff[1:0] == 2'b00);
  assign slot_b   = hoff[2];
  assign sn       = hoff[5:3];

  // Refetch of POS/CTL (zero height or end of sprite) passes through FETCHCTL
  // so slot B picks up CTL; the sprite is back in WAIT once slot B is done.
  always_comb begin
    fetch = 1'b0;
    kind  = K_POS;
    nxt   = state_q[sn];
    if (slot_hit && spren && !reset) begin
      unique case (state_q[sn])
        IDLE: if (!slot_b && verbeam == VBEND) begin
          fetch = 1'b1; kind = K_POS; nxt = FETCHCTL;
        end
        FETCHCTL: if (slot_b) begin
          fetch = 1'b1; kind = K_CTL; nxt = WAIT;
        end
        WAIT: if (!slot_b && verbeam == vstart_q[sn]) begin
          fetch = 1'b1;
          if (vstart_q[sn] == vstop_q[sn]) begin
            kind = K_POS; nxt = FETCHCTL;
          end else begin
            kind = K_DATA; nxt = DATA;
          end
        end
        DATA: begin
          fetch = 1'b1;
          if (slot_b) begin
            kind = K_DATB;
          end else if (verbeam == vstop_q[sn]) begin
            kind = K_POS; nxt = FETCHCTL;
          end else begin
            kind = K_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign dma             = fetch;
  assign address_out     = fetch ? ptr_q[sn] : '0;
  assign reg_address_out = fetch ? {3'b101, sn, kind} : 8'hFF;

  logic [7:0] snoop_addr;
  logic       snoop_spr;
  logic       ptr_wr;

  assign snoop_addr = dma ? reg_address_out : reg_address_in;
  assign snoop_spr  = (snoop_addr[7:5] == 3'b101);
  assign ptr_wr     = (reg_address_in[7:4] == 4'h9);

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      state_d[i]  = state_q[i];
      ptr_d[i]    = ptr_q[i];
      vstart_d[i] = vstart_q[i];
      vstop_d[i]  = vstop_q[i];

      if (fetch && sn == i[2:0]) begin
        state_d[i] = nxt;
        ptr_d[i]   = ptr_q[i] + 20'd1;
      end

      // A CPU pointer write replaces the incremented value outright.
      if (ptr_wr && reg_address_in[3:1] == i[2:0]) begin
        ptr_d[i] = ptr_q[i];
        if (!reg_address_in[0]) ptr_d[i][19:15] = data_in[4:0];
        else                    ptr_d[i][14:0]  = data_in[15:1];
      end

      if (snoop_spr && snoop_addr[4:2] == i[2:0]) begin
        if (snoop_addr[1:0] == 2'd0) begin
          vstart_d[i][7:0] = data_in[15:8];
        end else if (snoop_addr[1:0] == 2'd1) begin
          vstop_d[i][7:0] = data_in[15:8];
          vstart_d[i][8]  = data_in[2];
          vstop_d[i][8]   = data_in[1];
          if (!dma && state_q[i] == DATA) state_d[i] = WAIT;
        end
      end

      if (horbeam == 9'd0 && verbeam == 9'd0) state_d[i] = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 8; i++) begin
      if (reset) begin
        state_q[i]  <= IDLE;
        ptr_q[i]    <= '0;
        vstart_q[i] <= '0;
        vstop_q[i]  <= '0;
      end else begin
        state_q[i]  <= state_d[i];
        ptr_q[i]    <= ptr_d[i];
        vstart_q[i] <= vstart_d[i];
        vstop_q[i]  <= vstop_d[i];
      end
    end
  end

endmodule

// File: doc/sprdma.md
SPRDMA -- requirements
Module: sprdma

Interface
REQ-001 The block SHALL have parameter VBEND, default 9'd25: first line on which sprite control words are fetched.
REQ-002 The block SHALL have parameter SLOTBASE, default 9'd42: horbeam value of sprite 0 slot A.
REQ-003 clk  input  1  bus clock, one low-res pixel per cycle; the single clock of the block.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 spren  input  1  sprite DMA enable (DMACON DMAEN and SPREN).
REQ-006 horbeam  input  9  horizontal beam counter, low-res pixels.
REQ-007 verbeam  input  9  vertical beam counter, lines.
REQ-008 reg_address_in  input  8  register address [8:1] of the current CPU or copper bus write.
REQ-009 data_in  input  16  bus data: the CPU write data, or the chip RAM word during own DMA.
REQ-010 dma  output  1  own DMA cycle this clk.
REQ-011 address_out  output  20  chip RAM word address [20:1], valid when dma=1.
REQ-012 reg_address_out  output  8  destination register [8:1] for the fetched word; 8'hFF when dma=0.

Function
REQ-013 The block SHALL hold, per sprite n (0..7), a pointer ptr[20:1], vstart[8:0], vstop[8:0] and a state from {IDLE, FETCHCTL, WAIT, DATA}.
REQ-014 Sprite n SHALL own slot A at horbeam=SLOTBASE+8n and slot B at horbeam=SLOTBASE+8n+4; each slot SHALL last one clk, and no other clk SHALL assert dma.
REQ-015 At a slot with spren=0, the block SHALL drive dma=0 and leave the state and ptr of sprite n unchanged.
REQ-016 At horbeam=0 with verbeam=0, every sprite SHALL enter IDLE.
REQ-017 IDLE: at slot A with verbeam=VBEND, the block SHALL fetch SPRnPOS and go to FETCHCTL.
REQ-018 FETCHCTL: at slot B, the block SHALL fetch SPRnCTL and go to WAIT.
REQ-019 WAIT: at slot A with verbeam=vstart and vstart!=vstop, the block SHALL fetch SPRnDATA, go to DATA, and fetch SPRnDATB at slot B.
REQ-020 WAIT with verbeam=vstart=vstop: the block SHALL treat the sprite as zero height, fetch POS at A and CTL at B, and remain in WAIT.
REQ-021 DATA: at slot A with verbeam=vstop, the block SHALL fetch POS at A and CTL at B and go to WAIT; otherwise it SHALL fetch DATA at A and DATB at B.
REQ-022 Each fetch SHALL drive address_out=ptr and then set ptr to ptr+1, wrapping modulo 2^20.
REQ-023 reg_address_out SHALL be 8'hA0+4n+k, with k=0 for POS, 1 for CTL, 2 for DATA and 3 for DATB.
REQ-024 Snoop: every clk, using (dma ? reg_address_out : reg_address_in) with data_in:
  - on a POS write, vstart[7:0]<=data_in[15:8];
  - on a CTL write, vstop[7:0]<=data_in[15:8], vstart[8]<=data_in[2], vstop[8]<=data_in[1].
REQ-025 A CTL write from reg_address_in to sprite n in state DATA SHALL force WAIT at the next clk.
REQ-026 A write to SPRnPTH (reg 9'h120+4n) SHALL load ptr[20:16]<=data_in[4:0].
REQ-027 A write to SPRnPTL (reg 9'h122+4n) SHALL load ptr[15:1]<=data_in[15:1].
REQ-028 When a pointer write and an own increment of the same sprite occur in one clk, the write SHALL win.
REQ-029 dma, address_out and reg_address_out SHALL be combinational from state and horbeam, with no wait states.

Reset
REQ-030 While reset=1, all states SHALL be IDLE; ptr, vstart and vstop SHALL be 0; dma=0; address_out=0; reg_address_out=8'hFF.
REQ-031 Reset asserted mid-line SHALL abort any pending slot B fetch; no DMA SHALL occur until verbeam=VBEND after reset releases.
REQ-032 Reset SHALL release on the clk after reset falls.

Verification
REQ-033 Startup:
  - stimulus: SPR0PTL=16'h1000, spren=1, verbeam=25, horbeam=42 then 46;
  - response: address_out 20'h00800 with reg 8'hA0, then 20'h00801 with reg 8'hA1; state WAIT.
REQ-034 Display:
  - stimulus: POS word 16'h3050, CTL word 16'h3400, lines 0x30..0x34;
  - response: lines 0x30..0x33 fetch DATA/DATB (regs 8'hA2/8'hA3, ptr +2 per line); line 0x34 fetches POS/CTL.
REQ-035 Slot position:
  - stimulus: sprite 7 active on the current line;
  - response: dma=1 exactly at horbeam 98 and 102 and at no other horbeam for sprite 7.
REQ-036 Disable:
  - stimulus: spren=0 for a whole line while a sprite is in DATA;
  - response: no dma; ptr and state unchanged; fetching resumes on the next line with spren=1.
REQ-037 Zero height:
  - stimulus: CTL word giving vstop=vstart;
  - response: no DATA fetch; POS/CTL refetched on the vstart line.
REQ-038 Pointer write collision:
  - stimulus: CPU writes SPR2PTL=16'h2000 on the clk of sprite 2 slot A;
  - response: ptr[15:1]=15'h1000, with no increment applied that clk.
